// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, bit-timing helper and frame constants.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    typedef struct packed {
        int unsigned cpb;
        int unsigned half;
    } uart_timing_t;

    function automatic uart_timing_t uart_timing(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
        uart_timing_t t;
        t.cpb  = clock_freq / baud_rate;
        t.half = t.cpb / 2;
        return t;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous circular receive buffer; the pointer MSB separates full from empty.
module uart_rx_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned PtrW  = AddrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_q, rd_q;
    logic             do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AddrW] != rd_q[AddrW]) && (wr_q[AddrW-1:0] == rd_q[AddrW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_q[AddrW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q[AddrW-1:0]] <= wdata;
                wr_q                   <= wr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PtrW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo_top.sv
// 8N1 UART receiver with a valid/ready read port. Define UART_RX_FIFO_EN for a
// FIFO_DEPTH-entry buffer; otherwise a single holding register is used.
module uart_rx_fifo_top
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      serial_in,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic                      frame_err,
    output logic                      overrun,
    input  logic                      overrun_clr,
    output logic                      busy
);

    localparam uart_timing_t Timing = uart_timing(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned  Cpb    = Timing.cpb;
    localparam int unsigned  Half   = Timing.half;
    localparam int unsigned  CntW   = $clog2(Cpb);
    localparam int unsigned  IdxW   = $clog2(UART_DATA_BITS);

    logic [1:0]                sync_q;
    logic                      rx;
    rx_state_e                 state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      push_q, push_d;
    logic                      ferr_q, ferr_d;
    logic                      overrun_q;
    logic                      pop, drop;
    logic                      cnt_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_in};
        end
    end

    assign rx       = sync_q[1];
    assign cnt_done = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            push_q  <= push_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx) begin
                    state_d = StStart;
                    cnt_d   = CntW'(Half - 1);
                end
            end
            StStart: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (rx) begin
                    state_d = StIdle;
                end else begin
                    state_d = StData;
                    idx_d   = '0;
                    cnt_d   = CntW'(Cpb - 1);
                end
            end
            StData: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    shift_d[idx_q] = rx;
                    cnt_d          = CntW'(Cpb - 1);
                    if (idx_q == IdxW'(UART_DATA_BITS - 1)) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StStop: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StIdle;
                    push_d  = rx;
                    ferr_d  = !rx;
                end
            end
        endcase
    end

    assign pop = data_valid && data_ready;

`ifdef UART_RX_FIFO_EN
    logic fifo_full, fifo_empty;

    uart_rx_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .pop   (pop),
        .wdata (shift_q),
        .rdata (data_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign data_valid = !fifo_empty;
    assign drop       = push_q && fifo_full && !pop;
`else
    logic [UART_DATA_BITS-1:0] hold_q;
    logic                      hold_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            if (pop) begin
                hold_valid_q <= 1'b0;
            end
            if (push_q && (!hold_valid_q || data_ready)) begin
                hold_q       <= shift_q;
                hold_valid_q <= 1'b1;
            end
        end
    end

    assign data_out   = hold_q;
    assign data_valid = hold_valid_q;
    assign drop       = push_q && hold_valid_q && !data_ready;
`endif

    // A new drop outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun   = overrun_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != StIdle);

    cfg_chk: assert property (@(posedge clk) (Cpb >= 4) && (FIFO_DEPTH >= 2));

endmodule

// File: tb/tb_uart_rx_fifo_top.sv
// Scoreboard bench for uart_rx_fifo_top: frames go out on serial_in, expected bytes queue up,
// and a negedge monitor pops and compares every accepted transfer.
module tb_uart_rx_fifo_top;

    localparam int unsigned ClockFreq = 50_000_000;
    localparam int unsigned BaudRate  = 1_000_000;
    localparam int unsigned Cpb       = ClockFreq / BaudRate;
    localparam int unsigned HalfBit   = Cpb / 2;
`ifdef UART_RX_FIFO_EN
    localparam int unsigned Depth = 8;
`else
    localparam int unsigned Depth = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       overrun_clr;
    logic       busy;

    uart_rx_fifo_top #(
        .CLOCK_FREQ (ClockFreq),
        .BAUD_RATE  (BaudRate),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .serial_in   (serial_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         valid_rise_cyc = -1;
    int         ferr_cnt = 0;
    int         xfer_cnt = 0;
    bit         rand_ready = 1'b0;
    bit         model_overrun = 1'b0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) data_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: one accepted transfer per negedge with valid && ready.
    initial begin
        logic       pv, pr, prst;
        logic [7:0] pd;
        pv = 1'b0; pr = 1'b0; prst = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (data_valid && data_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", {24'h0, data_out}, 32'hffff_ffff);
                    end else begin
                        check("rx_byte", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
                    end
                    xfer_cnt++;
                end
                if (prst && pv && !pr && data_valid) begin
                    check("data_out_stable", {24'h0, data_out}, {24'h0, pd});
                end
                if (frame_err) ferr_cnt++;
                if (data_valid && !pv) valid_rise_cyc = cyc;
            end
            pv = data_valid; pr = data_ready; pd = data_out; prst = rst_n;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives nbits of an 8N1 frame; only a complete frame with a good stop enters the model.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int nbits,
                              output int start_cyc);
        logic [9:0] frame;
        frame = {stop_ok, b, 1'b0};
        if (nbits == 10 && stop_ok) begin
            if (exp_q.size() < Depth) exp_q.push_back(b);
            else model_overrun = 1'b1;
        end
        @(posedge clk);
        #1;
        start_cyc = cyc;
        for (int i = 0; i < nbits; i++) begin
            serial_in = frame[i];
            repeat (Cpb) @(posedge clk);
            #1;
        end
        if (nbits == 10) serial_in = 1'b1;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 200;
        data_ready = 1'b1;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_data_out"}, {24'h0, data_out}, 0);
        check({tag, "_data_valid"}, {31'h0, data_valid}, 0);
        check({tag, "_frame_err"}, {31'h0, frame_err}, 0);
        check({tag, "_overrun"}, {31'h0, overrun}, 0);
        check({tag, "_busy"}, {31'h0, busy}, 0);
    endtask

    initial begin
        int         st, x0, f0;
        logic [7:0] burst [4];
        burst = '{8'h78, 8'h79, 8'h7A, 8'h0D};

        rst_n = 1'b0; serial_in = 1'b1; data_ready = 1'b0; overrun_clr = 1'b0;
        idle(4);
        check_reset_outputs("in_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(5);
        check_reset_outputs("after_reset");

        // Single byte, exact latency from the line edge to data_valid.
        data_ready = 1'b1;
        x0 = xfer_cnt;
        send_frame(8'h78, 1'b1, 10, st);
        idle(2 * Cpb);
        check("latency", valid_rise_cyc - st, 2 + HalfBit + 9 * Cpb + 2);
        check("single_xfers", xfer_cnt - x0, 1);

        // Back-to-back burst while the consumer stalls.
        data_ready = 1'b0;
        x0 = xfer_cnt;
        foreach (burst[i]) send_frame(burst[i], 1'b1, 10, st);
        idle(5);
        check("burst_stalled", xfer_cnt - x0, 0);
        check("burst_valid", {31'h0, data_valid}, 1);
        check("burst_overrun", {31'h0, overrun}, {31'h0, model_overrun});
        drain("burst_drain");
        check("burst_xfers", xfer_cnt - x0, (Depth < 4) ? Depth : 4);
        overrun_clr = 1'b1; idle(1); overrun_clr = 1'b0; model_overrun = 1'b0;
        idle(1);
        check("burst_overrun_clr", {31'h0, overrun}, 0);

        // False start: short low pulse.
        x0 = xfer_cnt; f0 = ferr_cnt;
        serial_in = 1'b0;
        idle(5);
        @(negedge clk);
        check("false_start_busy_hi", {31'h0, busy}, 1);
        idle(5);
        serial_in = 1'b1;
        idle(2 * Cpb);
        check("false_start_busy_lo", {31'h0, busy}, 0);
        check("false_start_xfers", xfer_cnt - x0, 0);
        check("false_start_ferr", ferr_cnt - f0, 0);

        // Framing error: stop bit driven low.
        x0 = xfer_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, 10, st);
        idle(3 * Cpb);
        check("ferr_pulses", ferr_cnt - f0, 1);
        check("ferr_xfers", xfer_cnt - x0, 0);
        check("ferr_valid", {31'h0, data_valid}, 0);
        check("ferr_busy", {31'h0, busy}, 0);

        // Overrun: nine bytes into a stalled buffer.
        data_ready = 1'b0;
        x0 = xfer_cnt;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 10, st);
        idle(5);
        check("ovr_flag", {31'h0, overrun}, {31'h0, model_overrun});
        drain("ovr_drain");
        check("ovr_xfers", xfer_cnt - x0, (Depth < 9) ? Depth : 9);
        check("ovr_sticky", {31'h0, overrun}, {31'h0, model_overrun});
        overrun_clr = 1'b1; idle(1); overrun_clr = 1'b0; model_overrun = 1'b0;
        idle(1);
        check("ovr_clr", {31'h0, overrun}, 0);

        // Reset mid-frame with a byte already buffered.
        data_ready = 1'b0;
        send_frame(8'h11, 1'b1, 10, st);
        idle(5);
        check("pre_reset_valid", {31'h0, data_valid}, 1);
        send_frame(8'hA5, 1'b1, 5, st);
        idle(Cpb / 2);
        rst_n = 1'b0;
        serial_in = 1'b1;
        exp_q.delete();
        model_overrun = 1'b0;
        check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(Cpb);
        check_reset_outputs("post_reset");
        data_ready = 1'b1;
        x0 = xfer_cnt;
        send_frame(8'h3E, 1'b1, 10, st);
        idle(2 * Cpb);
        check("post_reset_xfers", xfer_cnt - x0, 1);

        // Random bytes, random idle gaps, randomly stalling consumer.
        x0 = xfer_cnt;
        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send_frame(8'($urandom), 1'b1, 10, st);
            idle($urandom_range(0, Cpb));
        end
        idle(Cpb);
        rand_ready = 1'b0;
        idle(1);
        drain("rand_drain");
        check("rand_xfers", xfer_cnt - x0, 12);
        check("rand_overrun", {31'h0, overrun}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
